ls_backtrack_ctrl: RTL and testbench

// - Backtracking line-search controller; the producing side of the Armijo compare path.
// - Issues trial step alphai and asks the external cost evaluator for phi(alphai).
// - Launches the fixed-latency LS_Compare unit and consumes result_compare.
// - On reject: alphai <= alphai*tau. Repeats until accept or MAX_ITER trials.

---
 rtl/ls_pkg.sv | 60 ++++++
 rtl/ls_backtrack_ctrl_if.sv | 28 ++
 rtl/ls_backtrack_ctrl_fp_mul.sv | 37 +++
 rtl/ls_backtrack_ctrl.sv | 135 +++++++++++++
 tb/tb_ls_backtrack_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/ls_pkg.sv
// Shared definitions for the backtracking line-search datapath: FSM states,
// fp32 constants, latency defaults and the fp32 multiply helper.
package ls_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EVAL      = 3'd1,
        ST_WAIT_EVAL = 3'd2,
        ST_COMPARE   = 3'd3,
        ST_SCALE     = 3'd4,
        ST_FINISH    = 3'd5
    } ls_state_t;

    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_HALF = 32'h3F00_0000;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_MAX_ITER    = 16;
    localparam int DEF_CMP_LATENCY = 12;
    localparam int DEF_MUL_LATENCY = 8;

    // Round-to-nearest-even fp32 multiply; denormal operands and underflow flush to signed zero.
    function automatic logic [31:0] fp32_mul(input logic [31:0] a, input logic [31:0] b);
        logic        sign;
        logic [9:0]  exp_v;
        logic [47:0] prod;
        logic [22:0] frac;
        logic        rnd;
        logic [30:0] mag;
        logic [31:0] res;
        sign  = a[31] ^ b[31];
        prod  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        exp_v = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (prod[47]) begin
            frac  = prod[46:24];
            rnd   = prod[23] & ((|prod[22:0]) | prod[24]);
            exp_v = exp_v + 10'd1;
        end else begin
            frac  = prod[45:23];
            rnd   = prod[22] & ((|prod[21:0]) | prod[23]);
        end
        // A rounding carry out of the fraction ripples into the exponent field.
        mag = {exp_v[7:0], frac} + {30'd0, rnd};
        if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0)) begin
            res = 32'h7FC0_0000;
        end else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            res = {sign, 8'hFF, 23'd0};
        end else if (a[30:23] == 8'h00 || b[30:23] == 8'h00) begin
            res = {sign, 31'd0};
        end else if (exp_v[9] || exp_v == 10'd0) begin
            res = {sign, 31'd0};
        end else if (exp_v >= 10'd255) begin
            res = {sign, 8'hFF, 23'd0};
        end else begin
            res = {sign, mag};
        end
        return res;
    endfunction

endpackage

// File: rtl/ls_backtrack_ctrl_if.sv
// Controller-side bus: search request/result plus the evaluator and compare handshakes.
interface ls_backtrack_ctrl_if #(
    parameter int ITER_W = 5
);
    logic              start;
    logic [31:0]       alpha_init;
    logic [31:0]       tau;
    logic [31:0]       alphai;
    logic              eval_req;
    logic              eval_done;
    logic              cmp_start;
    logic              result_compare;
    logic              busy;
    logic              done;
    logic              accepted;
    logic [31:0]       alpha_out;
    logic [ITER_W-1:0] iter_count;

    modport master (
        input  start, alpha_init, tau, eval_done, result_compare,
        output alphai, eval_req, cmp_start, busy, done, accepted, alpha_out, iter_count
    );

    modport slave (
        output start, alpha_init, tau, eval_done, result_compare,
        input  alphai, eval_req, cmp_start, busy, done, accepted, alpha_out, iter_count
    );
endinterface

// File: rtl/ls_backtrack_ctrl_fp_mul.sv
// ls_fp_mul: fp32 multiplier with a fixed MUL_LATENCY valid-in/valid-out pipeline.
module ls_fp_mul
    import ls_pkg::*;
#(
    parameter int MUL_LATENCY = DEF_MUL_LATENCY
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] y
);
    logic [31:0]            data_r [MUL_LATENCY];
    logic [MUL_LATENCY-1:0] valid_r;

    // Product computed in the first stage, then delayed through the remaining stages.
    always_ff @(posedge aclk) begin
        if (areset) begin
            valid_r <= {MUL_LATENCY{1'b0}};
            for (int i = 0; i < MUL_LATENCY; i++) begin
                data_r[i] <= 32'd0;
            end
        end else begin
            valid_r[0] <= in_valid;
            data_r[0]  <= fp32_mul(a, b);
            for (int i = 1; i < MUL_LATENCY; i++) begin
                valid_r[i] <= valid_r[i-1];
                data_r[i]  <= data_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[MUL_LATENCY-1];
    assign y         = data_r[MUL_LATENCY-1];
endmodule

// File: rtl/ls_backtrack_ctrl.sv
// Backtracking line-search controller: issues trial steps, waits for the cost
// evaluator, times the fixed-latency Armijo compare and shrinks alpha by tau on reject.
module ls_backtrack_ctrl
    import ls_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MAX_ITER    = DEF_MAX_ITER,
    parameter int CMP_LATENCY = DEF_CMP_LATENCY,
    parameter int MUL_LATENCY = DEF_MUL_LATENCY
) (
    input  logic                aclk,
    input  logic                areset,
    ls_backtrack_ctrl_if.master bus
);
    localparam int ITER_W = $clog2(MAX_ITER + 1);
    localparam int LAT_W  = $clog2(CMP_LATENCY + 1);
    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(CMP_LATENCY);

    ls_state_t             state_r;
    logic [DATA_WIDTH-1:0] alphai_r;
    logic [DATA_WIDTH-1:0] tau_r;
    logic [DATA_WIDTH-1:0] alpha_out_r;
    logic [ITER_W-1:0]     iter_r;
    logic [LAT_W-1:0]      lat_cnt_r;
    logic                  eval_req_r;
    logic                  cmp_start_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  accepted_r;
    logic                  mul_start_r;
    logic                  mul_valid_s;
    logic [DATA_WIDTH-1:0] mul_y_s;

    ls_fp_mul #(.MUL_LATENCY(MUL_LATENCY)) u_mul (
        .aclk      (aclk),
        .areset    (areset),
        .in_valid  (mul_start_r),
        .a         (alphai_r),
        .b         (tau_r),
        .out_valid (mul_valid_s),
        .y         (mul_y_s)
    );

    // Search FSM with latency and iteration counters; every output is registered.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r     <= ST_IDLE;
            alphai_r    <= 32'd0;
            tau_r       <= 32'd0;
            alpha_out_r <= 32'd0;
            iter_r      <= {ITER_W{1'b0}};
            lat_cnt_r   <= {LAT_W{1'b0}};
            eval_req_r  <= 1'b0;
            cmp_start_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            accepted_r  <= 1'b0;
            mul_start_r <= 1'b0;
        end else begin
            eval_req_r  <= 1'b0;
            cmp_start_r <= 1'b0;
            done_r      <= 1'b0;
            mul_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        alphai_r <= bus.alpha_init;
                        tau_r    <= bus.tau;
                        iter_r   <= {ITER_W{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= ST_EVAL;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_EVAL: begin
                    eval_req_r <= 1'b1;
                    state_r    <= ST_WAIT_EVAL;
                end
                ST_WAIT_EVAL: begin
                    if (bus.eval_done) begin
                        cmp_start_r <= 1'b1;
                        iter_r      <= iter_r + ITER_W'(1);
                        lat_cnt_r   <= {LAT_W{1'b0}};
                        state_r     <= ST_COMPARE;
                    end else begin
                        state_r     <= ST_WAIT_EVAL;
                    end
                end
                // The verdict is sampled CMP_LATENCY cycles after the cmp_start cycle;
                // done is raised on that edge so FINISH is the done cycle itself.
                ST_COMPARE: begin
                    if (lat_cnt_r == LAT_LAST) begin
                        if (bus.result_compare || iter_r == ITER_MAX) begin
                            accepted_r  <= bus.result_compare;
                            alpha_out_r <= alphai_r;
                            done_r      <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= ST_FINISH;
                        end else begin
                            mul_start_r <= 1'b1;
                            state_r     <= ST_SCALE;
                        end
                    end else begin
                        lat_cnt_r <= lat_cnt_r + LAT_W'(1);
                    end
                end
                ST_SCALE: begin
                    if (mul_valid_s) begin
                        alphai_r <= mul_y_s;
                        state_r  <= ST_EVAL;
                    end else begin
                        state_r  <= ST_SCALE;
                    end
                end
                ST_FINISH: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.alphai     = alphai_r;
    assign bus.eval_req   = eval_req_r;
    assign bus.cmp_start  = cmp_start_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.accepted   = accepted_r;
    assign bus.alpha_out  = alpha_out_r;
    assign bus.iter_count = iter_r;
endmodule

// File: tb/tb_ls_backtrack_ctrl.sv
// Scoreboard bench for ls_backtrack_ctrl with an evaluator/compare stub driven inline.
module tb_ls_backtrack_ctrl;
    localparam int MAX_ITER = 4;
    localparam int CMP_LAT  = 12;
    localparam int MUL_LAT  = 8;
    localparam int ITER_W   = $clog2(MAX_ITER + 1);

    typedef struct {
        logic        accepted;
        logic [31:0] alpha_out;
        int          iters;
    } exp_t;

    logic aclk;
    logic areset;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    ls_backtrack_ctrl_if #(.ITER_W(ITER_W)) bus ();

    ls_backtrack_ctrl #(
        .MAX_ITER    (MAX_ITER),
        .CMP_LATENCY (CMP_LAT),
        .MUL_LATENCY (MUL_LAT)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge aclk);
    endtask

    function automatic logic [31:0] real_to_sp(input real r);
        logic [63:0] d;
        logic [7:0]  e;
        d = $realtobits(r);
        e = 8'(d[62:52] - 11'd896);
        if (r == 0.0) return 32'd0;
        return {d[63], e, d[51:29]};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ctl"}, {27'd0, bus.eval_req, bus.cmp_start, bus.busy, bus.done, bus.accepted}, 32'd0);
        check_val({tag, "_alphai"}, bus.alphai, 32'd0);
        check_val({tag, "_alpha_out"}, bus.alpha_out, 32'd0);
        check_val({tag, "_iter"}, 32'(bus.iter_count), 32'd0);
    endtask

    // pass_trial=0 never passes; abort_trial>0 resets during that trial's compare window.
    task automatic run_search(input real a0, input real t, input int pass_trial,
                              input int delay, input bit stray, input int abort_trial);
        exp_t        e;
        real         a;
        int          n;
        int          cyc;
        bit          pass;
        bit          fin;
        bit          stable;
        bit          saw_done;
        logic [31:0] held;
        n = (pass_trial >= 1 && pass_trial <= MAX_ITER) ? pass_trial : MAX_ITER;
        a = a0;
        for (int i = 1; i < n; i++) a = a * t;
        e.accepted  = (pass_trial >= 1 && pass_trial <= MAX_ITER);
        e.alpha_out = real_to_sp(a);
        e.iters     = n;
        sb_q.push_back(e);

        a = a0;
        bus.alpha_init = real_to_sp(a0);
        bus.tau        = real_to_sp(t);
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.eval_req && cyc < 50) begin
            tick();
            cyc++;
        end
        check_val("start_to_eval_req", 32'(cyc), 32'd2);
        check_val("busy_in_search", {31'd0, bus.busy}, 32'd1);

        for (int tr = 1; tr <= MAX_ITER; tr++) begin
            check_val("alphai_trial", bus.alphai, real_to_sp(a));
            held   = bus.alphai;
            stable = 1'b1;
            for (int d = 0; d <= delay; d++) begin
                tick();
                if (bus.alphai !== held) stable = 1'b0;
            end
            bus.eval_done = 1'b1;
            tick();
            bus.eval_done = 1'b0;
            check_val("cmp_start_after_eval_done", {31'd0, bus.cmp_start}, 32'd1);
            pass = (tr == pass_trial);
            bus.result_compare = ~pass;
            for (int k = 1; k <= CMP_LAT; k++) begin
                tick();
                if (bus.alphai !== held) stable = 1'b0;
                if (stray && k == 1) begin
                    bus.start      = 1'b1;
                    bus.eval_done  = 1'b1;
                    bus.alpha_init = 32'h4000_0000;
                end else begin
                    bus.start      = 1'b0;
                    bus.eval_done  = 1'b0;
                end
                if (tr == abort_trial && k == 3) begin
                    bus.result_compare = 1'b0;
                    areset = 1'b1;
                    tick();
                    areset = 1'b0;
                    check_reset_outputs("abort");
                    saw_done = 1'b0;
                    for (int w = 0; w < CMP_LAT + 5; w++) begin
                        tick();
                        if (bus.done) saw_done = 1'b1;
                    end
                    check_val("abort_no_done", {31'd0, saw_done}, 32'd0);
                    void'(sb_q.pop_back());
                    return;
                end
                bus.result_compare = (k == CMP_LAT) ? pass : ~pass;
            end
            tick();
            bus.result_compare = 1'b0;
            check_val("alphai_stable", {31'd0, stable}, 32'd1);
            fin = pass || (tr == MAX_ITER);
            check_val("done_timing", {31'd0, bus.done}, {31'd0, fin});
            if (fin) begin
                check_val("busy_at_done", {31'd0, bus.busy}, 32'd0);
                e = sb_q.pop_front();
                check_val("accepted", {31'd0, bus.accepted}, {31'd0, e.accepted});
                check_val("alpha_out", bus.alpha_out, e.alpha_out);
                check_val("iter_count", 32'(bus.iter_count), 32'(e.iters));
                tick();
                check_val("done_one_pulse", {31'd0, bus.done}, 32'd0);
                return;
            end
            a = a * t;
            cyc = 0;
            while (!bus.eval_req && cyc < 100) begin
                tick();
                cyc++;
            end
            if (!bus.eval_req) begin
                check_val("eval_req_timeout", {31'd0, bus.eval_req}, 32'd1);
                void'(sb_q.pop_front());
                return;
            end
        end
    endtask

    initial begin
        areset             = 1'b1;
        bus.start          = 1'b0;
        bus.alpha_init     = 32'd0;
        bus.tau            = 32'd0;
        bus.eval_done      = 1'b0;
        bus.result_compare = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        areset = 1'b0;
        tick();

        run_search(1.0, 0.5, 3, 0, 1'b0, 0);
        run_search(1.0, 0.5, 0, 0, 1'b0, 0);
        run_search(1.0, 0.5, 1, 0, 1'b0, 0);
        run_search(1.0, 0.5, 3, 0, 1'b1, 0);
        run_search(1.0, 0.5, 3, 0, 1'b0, 2);
        run_search(1.0, 0.5, 3, 0, 1'b0, 0);
        run_search(1.0, 0.5, 2, 100, 1'b0, 0);
        run_search(2.0, 0.75, 3, 3, 1'b0, 0);

        check_val("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
